ifu: RTL
========

Name: ifu

Overview:
Instruction Fetch Unit. Sits directly upstream of the instruction decode unit.
- Maintains the program counter and issues word fetches to instruction memory over a request/grant/response handshake.
- Buffers returned 16-bit instructions in a small FIFO and presents them to decode with a valid/ready handshake.
- Supports a redirect that flushes buffered and in-flight fetches.

Parameters:
ADDR_W, 8, instruction word-address width (matches the 8-bit immediate/address field)
INSTR_W, 16, instruction width
DEPTH, 2, fetch buffer entries; also the cap on outstanding plus discarded plus buffered fetches
RESET_PC, 0, PC value after reset

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
en_i  input  1  fetch enable
redirect_i  input  1  redirect request (branch/jump), single-cycle pulse
redirect_addr_i  input  ADDR_W  new fetch address
imem_req_o  output  1  fetch request
imem_addr_o  output  ADDR_W  fetch word address
imem_gnt_i  input  1  request accepted this cycle
imem_rvalid_i  input  1  response valid; responses return in order, latency >= 1 cycle
imem_rdata_i  input  INSTR_W  response instruction
instr_o  output  INSTR_W  instruction to decode
instr_pc_o  output  ADDR_W  address of instr_o
instr_vld_o  output  1  instr_o valid
id_rdy_i  input  1  decode accepts instr_o

Behaviour:
- Reset (async, reset_n=0) state: pc=RESET_PC, resp_pc=RESET_PC, outstanding=0, discard=0, buffer empty, FSM=IDLE.
- Output values under reset: imem_req_o=0, imem_addr_o=RESET_PC, instr_vld_o=0, instr_o=0, instr_pc_o=0.
- Reset may assert mid-transaction; the memory is reset by the same reset_n.
- Credit: credit_ok = (outstanding_nxt + discard_nxt + count_nxt) < DEPTH, computed from next-state counter values.
- FSM states:
  - IDLE: imem_req_o=0. Go to REQ when en_i && credit_ok && !redirect_i.
  - REQ: imem_req_o=1 (forced 0 when redirect_i=1); imem_addr_o=pc, held stable until grant.
  - REQ on grant (req && gnt): pc<=pc+1, wrapping 2^ADDR_W-1 -> 0; outstanding++. Stay in REQ if en_i && credit_ok, else go to IDLE.
  - REQ, en_i deasserted while waiting: request is NOT withdrawn; stays in REQ until grant.
- Responses, on imem_rvalid_i:
  - discard>0: discard--, data dropped.
  - otherwise: write {imem_rdata_i, resp_pc} to buffer tail; resp_pc++ (wrapping); outstanding--.
  - Buffer overflow cannot occur because of credit; the bench asserts it.
  - imem_rvalid_i with outstanding==0 and discard==0 is a protocol error: ignored, and the bench flags it.
- Decode interface:
  - instr_vld_o = buffer non-empty && !redirect_i.
  - instr_o and instr_pc_o come from the head entry (registered storage; no response-to-output bypass).
  - Pop on instr_vld_o && id_rdy_i.
  - Minimum latency: req granted at cycle N, rvalid at N+1 gives instr_vld_o at N+2.
- Same-cycle events:
  - Grant and response together: outstanding is net unchanged.
  - Push and pop together: count is unchanged.
- Redirect (redirect_i=1), in that cycle:
  - No grant is counted.
  - Buffer is flushed and no pop occurs.
  - A response arriving that cycle is dropped.
  - discard <= discard + outstanding (after this cycle's response accounting); outstanding <= 0.
  - pc <= redirect_addr_i; resp_pc <= redirect_addr_i; FSM <= IDLE.
  - Fetch restarts from the new address on the next cycle if en_i && credit_ok.
- Counter bounds: all counters are clog2(DEPTH+1) bits; outstanding + discard + count <= DEPTH always holds.

Decomposition:
- Shared header ifu_defs.vh: FSM state encodings (IDLE, REQ), default ADDR_W/INSTR_W/DEPTH/RESET_PC.
- Sub-module fetch_buf: DEPTH-entry synchronous FIFO of {instr, pc}.
  - Ports: push, pop, flush, head outputs, count; asynchronous active-low reset.
  - ifu owns the FSM, pc/resp_pc, outstanding/discard counters and the credit logic.

Test Plan:
- Reset release, en_i=1, memory grants immediately with 1-cycle latency, id_rdy_i=1 -> imem_addr_o sequence 0,1,2,3,...; instr_vld_o first high 2 cycles after first grant; instr_pc_o 0,1,2,... matching data.
- id_rdy_i=0 with DEPTH=2 -> exactly 2 grants, then imem_req_o drops. After id_rdy_i=1, fetch resumes at addr 2 with no duplicate or lost instruction.
- Memory withholds grant 3 cycles while en_i toggles to 0 -> imem_req_o and imem_addr_o stay stable until grant; no further request after grant while en_i=0.
- 2 fetches in flight (addr 5,6), redirect_i to 0x40 -> both responses dropped, buffer empty. Next request addr 0x40; next instr_pc_o=0x40 with the 0x40 data.
- Redirect in the same cycle as a response and a decode pop -> response dropped, no pop, instr_vld_o=0 that cycle, discard count correct.
- pc=0xFF granted -> next imem_addr_o=0x00; instr_pc_o wraps 0xFF -> 0x00. reset_n pulsed low mid-fetch -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared types and default parameters for the instruction fetch unit.
package ifu_pkg;

    localparam int ADDR_W_DEF   = 8;
    localparam int INSTR_W_DEF  = 16;
    localparam int DEPTH_DEF    = 2;
    localparam int RESET_PC_DEF = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } ifu_state_e;

endpackage

// File: rtl/ifu_fetch_buf.sv
// DEPTH-entry synchronous FIFO holding {instr, pc}; flush empties it in one cycle.
module ifu_fetch_buf #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 24,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              flush,
    output logic [DATA_W-1:0] head_data,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Head comes straight from storage: no response-to-output bypass.
    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: PC, request/grant/response fetch engine with credit
// limiting, redirect flush and a small buffer feeding decode.
module ifu
    import ifu_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int INSTR_W  = INSTR_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int RESET_PC = RESET_PC_DEF
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               en_i,
    input  logic               redirect_i,
    input  logic [ADDR_W-1:0]  redirect_addr_i,
    output logic               imem_req_o,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic               imem_gnt_i,
    input  logic               imem_rvalid_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  instr_pc_o,
    output logic               instr_vld_o,
    input  logic               id_rdy_i,
    output ifu_state_e         dbg_state_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SUM_W = CNT_W + 2;
    localparam int BUF_W = INSTR_W + ADDR_W;
    localparam logic [ADDR_W-1:0] RESET_PC_L = ADDR_W'(RESET_PC);

    ifu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0]  out_q, out_d;
    logic [CNT_W-1:0]  disc_q, disc_d;

    logic              rsp_from_disc, rsp_from_out;
    logic              gnt_fire, buf_push, buf_pop;
    logic [CNT_W-1:0]  out_after, disc_after, count_nxt, buf_count;
    logic [SUM_W-1:0]  credit_sum;
    logic              credit_ok;
    logic [BUF_W-1:0]  head_data;

    always_comb begin
        rsp_from_disc = imem_rvalid_i && (disc_q != '0);
        // A response with nothing pending is a protocol error and is ignored.
        rsp_from_out  = imem_rvalid_i && (disc_q == '0) && (out_q != '0);
        gnt_fire      = (state_q == ST_REQ) && !redirect_i && imem_gnt_i;
        buf_push      = rsp_from_out && !redirect_i;
        instr_vld_o   = (buf_count != '0) && !redirect_i;
        buf_pop       = instr_vld_o && id_rdy_i;

        out_after  = out_q + CNT_W'(gnt_fire) - CNT_W'(rsp_from_out);
        disc_after = disc_q - CNT_W'(rsp_from_disc);

        if (redirect_i) begin
            // Everything still in flight becomes a response to throw away.
            out_d     = '0;
            disc_d    = disc_after + out_after;
            count_nxt = '0;
            pc_d      = redirect_addr_i;
            resp_pc_d = redirect_addr_i;
        end else begin
            out_d     = out_after;
            disc_d    = disc_after;
            count_nxt = buf_count + CNT_W'(buf_push) - CNT_W'(buf_pop);
            pc_d      = pc_q + ADDR_W'(gnt_fire);
            resp_pc_d = resp_pc_q + ADDR_W'(buf_push);
        end

        credit_sum = SUM_W'(out_d) + SUM_W'(disc_d) + SUM_W'(count_nxt);
        credit_ok  = credit_sum < SUM_W'(DEPTH);
    end

    always_comb begin
        state_d     = state_q;
        imem_req_o  = 1'b0;
        imem_addr_o = pc_q;
        case (state_q)
            ST_IDLE: begin
                if (en_i && credit_ok && !redirect_i) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // Once raised, the request is held until granted even if en_i drops.
                imem_req_o = !redirect_i;
                if (redirect_i) begin
                    state_d = ST_IDLE;
                end else if (imem_gnt_i) begin
                    state_d = (en_i && credit_ok) ? ST_REQ : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC_L;
            resp_pc_q <= RESET_PC_L;
            out_q     <= '0;
            disc_q    <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            resp_pc_q <= resp_pc_d;
            out_q     <= out_d;
            disc_q    <= disc_d;
        end
    end

    ifu_fetch_buf #(
        .DEPTH (DEPTH),
        .DATA_W(BUF_W),
        .CNT_W (CNT_W)
    ) u_fetch_buf (
        .clk      (clock),
        .rst_n    (reset_n),
        .push     (buf_push),
        .push_data({imem_rdata_i, resp_pc_q}),
        .pop      (buf_pop),
        .flush    (redirect_i),
        .head_data(head_data),
        .count    (buf_count)
    );

    assign instr_o     = head_data[BUF_W-1:ADDR_W];
    assign instr_pc_o  = head_data[ADDR_W-1:0];
    assign dbg_state_o = state_q;

endmodule
